// File: rtl/picorv32_wb_bridge_if.sv
// Core memory port plus Wishbone master bus, bundled for picorv32_wb_bridge.
// master: bridge side (takes mem_*, drives wbm_*); slave: core/interconnect side.
// With WB_BRIDGE_STALL_EN defined the bundle also carries wbm_stall_i.
interface picorv32_wb_bridge_if #(
   parameter int ADDR_WIDTH = 32
);
   logic                  mem_valid;
   logic [31:0]           mem_addr;
   logic [31:0]           mem_wdata;
   logic [3:0]            mem_wstrb;
   logic                  mem_ready;
   logic [31:0]           mem_rdata;
   logic [ADDR_WIDTH-1:0] wbm_adr_o;
   logic [31:0]           wbm_dat_o;
   logic [31:0]           wbm_dat_i;
   logic                  wbm_we_o;
   logic [3:0]            wbm_sel_o;
   logic                  wbm_stb_o;
   logic                  wbm_cyc_o;
   logic                  wbm_ack_i;
   logic                  wbm_err_i;
   logic                  wbm_rty_i;
`ifdef WB_BRIDGE_STALL_EN
   logic                  wbm_stall_i;
`endif

   modport master (
      input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
      output mem_ready, mem_rdata,
      output wbm_adr_o, wbm_dat_o, wbm_we_o, wbm_sel_o,
      output wbm_stb_o, wbm_cyc_o,
      input  wbm_dat_i, wbm_ack_i, wbm_err_i, wbm_rty_i
`ifdef WB_BRIDGE_STALL_EN
      , input wbm_stall_i
`endif
   );

   modport slave (
      output mem_valid, mem_addr, mem_wdata, mem_wstrb,
      input  mem_ready, mem_rdata,
      input  wbm_adr_o, wbm_dat_o, wbm_we_o, wbm_sel_o,
      input  wbm_stb_o, wbm_cyc_o,
      output wbm_dat_i, wbm_ack_i, wbm_err_i, wbm_rty_i
`ifdef WB_BRIDGE_STALL_EN
      , output wbm_stall_i
`endif
   );
endinterface

// File: rtl/picorv32_wb_bridge.sv
// picorv32 native memory port to Wishbone master, with bounded retry on
// wbm_rty_i, per-attempt timeout watchdog and failed-access reporting.
// Ports: wb_clk_i, wb_rst_i (sync, active-high); bus (mem_* / wbm_*, master
// modport); bus_err_o/bus_tmo_o pulses; err_addr_o, err_count_o (saturating).
// Macro WB_BRIDGE_STALL_EN selects B4 pipelined mode (wbm_stall_i).
module picorv32_wb_bridge #(
   parameter int          ADDR_WIDTH     = 32,
   parameter int          TIMEOUT_CYCLES = 256,
   parameter int          MAX_RETRIES    = 3,
   parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
   input  logic                 wb_clk_i,
   input  logic                 wb_rst_i,
   picorv32_wb_bridge_if.master bus,
   output logic                 bus_err_o,
   output logic                 bus_tmo_o,
   output logic [31:0]          err_addr_o,
   output logic [15:0]          err_count_o
);
   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACTIVE  = 2'd1,
      BACKOFF = 2'd2,
      DONE    = 2'd3
   } state_t;

   state_t                state_q, state_n;
   logic [ADDR_WIDTH-1:0] adr_q, adr_n;
   logic [31:0]           addr_q, addr_n;
   logic [31:0]           dat_q, dat_n;
   logic [31:0]           rdata_q, rdata_n;
   logic [31:0]           eaddr_q, eaddr_n;
   logic [15:0]           ecnt_q, ecnt_n;
   logic [3:0]            sel_q, sel_n;
   logic [3:0]            rcnt_q, rcnt_n;
   logic [TW-1:0]         tcnt_q, tcnt_n;
   logic                  we_q, we_n;
   logic                  cyc_q, cyc_n;
   logic                  stb_q, stb_n;
   logic                  fail, tmo, tmo_hit;

   assign tmo_hit = (TIMEOUT_CYCLES != 0) &&
                    (32'(tcnt_q) == 32'(TIMEOUT_CYCLES - 1));

   always_comb begin
      state_n = state_q;
      adr_n   = adr_q;
      addr_n  = addr_q;
      dat_n   = dat_q;
      rdata_n = rdata_q;
      eaddr_n = eaddr_q;
      ecnt_n  = ecnt_q;
      sel_n   = sel_q;
      rcnt_n  = rcnt_q;
      tcnt_n  = tcnt_q;
      we_n    = we_q;
      cyc_n   = cyc_q;
      stb_n   = stb_q;
      fail    = 1'b0;
      tmo     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.mem_valid) begin
               adr_n   = {bus.mem_addr[ADDR_WIDTH-1:2], 2'b00};
               addr_n  = bus.mem_addr;
               dat_n   = bus.mem_wdata;
               we_n    = |bus.mem_wstrb;
               sel_n   = (|bus.mem_wstrb) ? bus.mem_wstrb : 4'hF;
               cyc_n   = 1'b1;
               stb_n   = 1'b1;
               rcnt_n  = 4'd0;
               tcnt_n  = '0;
               state_n = ACTIVE;
            end
         end
         ACTIVE: begin
            tcnt_n = tcnt_q + 1'b1;
`ifdef WB_BRIDGE_STALL_EN
            // B4 pipelined: request is accepted on first non-stall cycle
            if (stb_q && !bus.wbm_stall_i)
               stb_n = 1'b0;
`endif
            if (bus.wbm_ack_i) begin
               if (!we_q)
                  rdata_n = bus.wbm_dat_i;
               cyc_n   = 1'b0;
               stb_n   = 1'b0;
               we_n    = 1'b0;
               state_n = DONE;
            end else if (bus.wbm_err_i ||
                         (bus.wbm_rty_i && rcnt_q == 4'(MAX_RETRIES))) begin
               fail = 1'b1;
            end else if (bus.wbm_rty_i) begin
               cyc_n   = 1'b0;
               stb_n   = 1'b0;
               rcnt_n  = rcnt_q + 4'd1;
               state_n = BACKOFF;
            end else if (tmo_hit) begin
               fail = 1'b1;
               tmo  = 1'b1;
            end
            if (fail) begin
               if (!we_q)
                  rdata_n = ERR_RDATA;
               eaddr_n = addr_q;
               if (ecnt_q != 16'hFFFF)
                  ecnt_n = ecnt_q + 16'd1;
               cyc_n   = 1'b0;
               stb_n   = 1'b0;
               we_n    = 1'b0;
               state_n = DONE;
            end
         end
         BACKOFF: begin
            cyc_n   = 1'b1;
            stb_n   = 1'b1;
            tcnt_n  = '0;
            state_n = ACTIVE;
         end
         DONE: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q <= IDLE;
         adr_q   <= '0;
         addr_q  <= '0;
         dat_q   <= '0;
         rdata_q <= '0;
         eaddr_q <= '0;
         ecnt_q  <= '0;
         sel_q   <= '0;
         rcnt_q  <= '0;
         tcnt_q  <= '0;
         we_q    <= 1'b0;
         cyc_q   <= 1'b0;
         stb_q   <= 1'b0;
      end else begin
         state_q <= state_n;
         adr_q   <= adr_n;
         addr_q  <= addr_n;
         dat_q   <= dat_n;
         rdata_q <= rdata_n;
         eaddr_q <= eaddr_n;
         ecnt_q  <= ecnt_n;
         sel_q   <= sel_n;
         rcnt_q  <= rcnt_n;
         tcnt_q  <= tcnt_n;
         we_q    <= we_n;
         cyc_q   <= cyc_n;
         stb_q   <= stb_n;
      end
   end

   // Failure pulses are flagged in the terminating cycle, ahead of mem_ready
   assign bus_err_o     = fail & ~wb_rst_i;
   assign bus_tmo_o     = tmo & ~wb_rst_i;
   assign bus.mem_ready = (state_q == DONE) & ~wb_rst_i;
   assign bus.mem_rdata = rdata_q;
   assign bus.wbm_adr_o = adr_q;
   assign bus.wbm_dat_o = dat_q;
   assign bus.wbm_we_o  = we_q;
   assign bus.wbm_sel_o = sel_q;
   assign bus.wbm_cyc_o = cyc_q;
   assign bus.wbm_stb_o = stb_q;
   assign err_addr_o    = eaddr_q;
   assign err_count_o   = ecnt_q;
endmodule
